// File: rtl/cw8_decoder.sv
// Receive-side decoder for the figure-8 segment chase: recovers the chase step
// from a one-hot segment bus, tracks lock to the forward sequence, counts errors.
module cw8_decoder #(
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_segment,
  input  logic             i_sample,
  output logic [2:0]       o_count,
  output logic             o_locked,
  output logic             o_error,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_e;

  localparam logic [6:0] SEG_A = 7'b0000001;
  localparam logic [6:0] SEG_B = 7'b0000010;
  localparam logic [6:0] SEG_C = 7'b0000100;
  localparam logic [6:0] SEG_D = 7'b0001000;
  localparam logic [6:0] SEG_E = 7'b0010000;
  localparam logic [6:0] SEG_F = 7'b0100000;
  localparam logic [6:0] SEG_G = 7'b1000000;

  localparam logic [2:0] LOCK_RUN = 3'(LOCK_LEN);

  typedef struct packed {
    logic       uniq;
    logic [2:0] step;
  } decode_t;

  // g is deliberately not unique: it is steps 2 and 6, so only history resolves it.
  function automatic decode_t decode(input logic [6:0] seg);
    decode_t d;
    d = '0;
    case (seg)
      SEG_A:   d = '{uniq: 1'b1, step: 3'd0};
      SEG_B:   d = '{uniq: 1'b1, step: 3'd1};
      SEG_E:   d = '{uniq: 1'b1, step: 3'd3};
      SEG_D:   d = '{uniq: 1'b1, step: 3'd4};
      SEG_C:   d = '{uniq: 1'b1, step: 3'd5};
      SEG_F:   d = '{uniq: 1'b1, step: 3'd7};
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] pattern_of(input logic [2:0] step);
    logic [6:0] p;
    case (step)
      3'd0:    p = SEG_A;
      3'd1:    p = SEG_B;
      3'd2:    p = SEG_G;
      3'd3:    p = SEG_E;
      3'd4:    p = SEG_D;
      3'd5:    p = SEG_C;
      3'd6:    p = SEG_G;
      default: p = SEG_F;
    endcase
    return p;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [2:0]       run_q,   run_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  decode_t    dec;
  logic [2:0] count_inc;
  logic [2:0] run_inc;
  logic       match;

  assign dec       = decode(i_segment);
  assign count_inc = count_q + 3'd1;
  assign run_inc   = run_q + 3'd1;
  // The expected pattern always advances, so a repeated pattern is a mismatch.
  assign match     = (i_segment == pattern_of(count_inc));

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    run_d     = run_q;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    if (i_sample) begin
      case (state_q)
        HUNT: begin
          if (dec.uniq) begin
            count_d = dec.step;
            run_d   = 3'd0;
            state_d = TRACK;
          end
        end

        TRACK: begin
          if (match) begin
            count_d = count_inc;
            run_d   = run_inc;
            if (run_inc == LOCK_RUN) state_d = LOCKED;
          end else if (dec.uniq) begin
            count_d = dec.step;
            run_d   = 3'd0;
          end else begin
            state_d = HUNT;
          end
        end

        LOCKED: begin
          if (match) begin
            count_d = count_inc;
          end else begin
            error_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (dec.uniq) begin
              count_d = dec.step;
              run_d   = 3'd0;
              state_d = TRACK;
            end else begin
              state_d = HUNT;
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  assign locked_d = (state_d == LOCKED);

  // NOTE: async assert clears the in-flight error pulse too; release is synchronised upstream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= HUNT;
      count_q   <= 3'd0;
      run_q     <= 3'd0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      run_q     <= run_d;
      locked_q  <= locked_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_count   = count_q;
  assign o_locked  = locked_q;
  assign o_error   = error_q;
  assign o_err_cnt = err_cnt_q;
  assign o_state   = state_q;

endmodule
